pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have: clk  in  1  system clock, all state rising-edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: pc_source  in  32  next-PC value from the PC-source mux (jump / PC+4 / branch / EPC).
REQ-004 SHALL have: pc_write  in  1  unconditional PC load enable.
REQ-005 SHALL have: pc_write_cond  in  1  conditional PC load enable (branch).
REQ-006 SHALL have: branch_taken  in  1  branch condition from ALU compare, qualifies pc_write_cond.
REQ-007 SHALL have: exc_valid  in  1  exception request, one-cycle pulse from control.
REQ-008 SHALL have: exc_code  in  2  cause: 00 invalid opcode, 01 overflow, 10 divide-by-zero, 11 reserved.
REQ-009 SHALL have: vec_rd_req  out  1  vector-byte memory read request.
REQ-010 SHALL have: vec_addr  out  32  vector-byte address.
REQ-011 SHALL have: vec_rd_data  in  8  returned vector byte.
REQ-012 SHALL have: vec_rd_valid  in  1  vec_rd_data valid, one cycle.
REQ-013 SHALL have: pc_out  out  32  current PC; feeds memory address and ALU.
REQ-014 SHALL have: epc_out  out  32  exception PC; feeds the EPC leg of the PC-source mux.
REQ-015 SHALL have: cause_out  out  2  latched exception cause.
REQ-016 SHALL have: exc_busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, LOAD.
REQ-018 In IDLE, pc_out SHALL load pc_source on the next edge when pc_write=1, or when pc_write_cond=1 and branch_taken=1; otherwise it SHALL hold.
REQ-019 In IDLE with exc_valid=1, the next edge SHALL set epc_out = pc_out - 32'd4 (mod 2^32), cause_out = exc_code, go to REQ, and leave pc_out unchanged.
REQ-020 When exc_valid and a PC write are asserted in the same IDLE cycle, the exception SHALL win and the PC write SHALL be dropped.
REQ-021 In REQ, vec_rd_req SHALL be 1 for exactly one cycle with vec_addr = 253 + cause (code 11 maps to 253); the FSM then SHALL go to WAIT.
REQ-022 vec_addr SHALL hold its value from REQ until LOAD completes; vec_rd_req SHALL be 0 outside REQ.
REQ-023 In WAIT, the FSM SHALL remain until vec_rd_valid=1, then capture vec_rd_data and go to LOAD; vec_rd_valid outside WAIT SHALL be ignored.
REQ-024 In LOAD, pc_out SHALL load {24'b0, captured byte} on the next edge, and the FSM SHALL return to IDLE.
REQ-025 While exc_busy=1, pc_write, pc_write_cond and exc_valid SHALL be ignored; a dropped exc_valid SHALL NOT change epc_out or cause_out.
REQ-026 epc_out and cause_out SHALL change only on REQ-019 captures.
REQ-027 Exception latency SHALL be 3 cycles + memory wait from the exc_valid edge to the new pc_out.

Reset
REQ-028 reset=0 SHALL immediately force pc_out=0, epc_out=0, cause_out=0, state=IDLE, vec_rd_req=0, vec_addr=0 and exc_busy=0, including mid-sequence.
REQ-029 After reset is released, the block SHALL resume normal operation on the first rising clk edge.

Structure
REQ-030 Package pc_unit_pkg SHALL hold the state encoding, the exception-code constants and VEC_BASE=32'd253.
REQ-031 The FSM plus the vector-address logic SHALL be one sub-module, pc_exc_fsm; the PC, EPC and cause registers SHALL stay in pc_unit.

Verification
REQ-032 Reset, then pc_write=1 with pc_source=0x00000004 -> pc_out=0x4 after one edge; a later cycle with pc_write=0 holds 0x4.
REQ-033 pc_write_cond=1, branch_taken=0, pc_source=0x40 -> pc_out unchanged; the same inputs with branch_taken=1 -> pc_out=0x40.
REQ-034 pc_out=0x108, exc_valid with code 01 -> epc_out=0x104, cause_out=01, one-cycle vec_rd_req at vec_addr=254; after 2 wait cycles, data 0x80 -> pc_out=0x80.
REQ-035 exc_valid and pc_write together in IDLE -> pc_out not written, sequence starts; a second exc_valid during WAIT -> epc_out and cause_out unchanged.
REQ-036 Reset asserted during WAIT -> all outputs 0 immediately, state IDLE; a late vec_rd_valid after reset release -> no effect.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// PC unit shared definitions: exception FSM encoding, cause codes and
// the base of the exception vector-byte table.
package pc_unit_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

    localparam logic [1:0] EXC_INV_OP = 2'b00;
    localparam logic [1:0] EXC_OVF    = 2'b01;
    localparam logic [1:0] EXC_DIV0   = 2'b10;
    localparam logic [1:0] EXC_RSVD   = 2'b11;

    localparam logic [31:0] VEC_BASE = 32'd253;

    // Reserved cause shares the invalid-opcode vector slot.
    function automatic logic [31:0] vec_addr_of(input logic [1:0] code);
        logic [31:0] w_addr;
        if (code == EXC_RSVD) begin
            w_addr = VEC_BASE;
        end else begin
            w_addr = VEC_BASE + {30'b0, code};
        end
        return w_addr;
    endfunction

endpackage

// File: rtl/pc_exc_fsm.sv
// Exception sequencer: fetches the handler vector byte from memory and
// tells the PC register when to load it.
module pc_exc_fsm
    import pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_exc_valid,
    input  logic [1:0]  i_exc_code,
    input  logic [7:0]  i_vec_rd_data,
    input  logic        i_vec_rd_valid,
    output logic        o_exc_take,
    output logic        o_load,
    output logic [7:0]  o_vec_byte,
    output logic        o_busy,
    output logic        o_vec_rd_req,
    output logic [31:0] o_vec_addr
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_vec_addr;
    logic [7:0]  r_vec_byte;
    logic        w_take;

    assign w_take = (r_state == ST_IDLE) && i_exc_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_exc_valid) w_state_nxt = ST_REQ;
            ST_REQ:  w_state_nxt = ST_WAIT;
            ST_WAIT: if (i_vec_rd_valid) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_vec_addr <= 32'd0;
            r_vec_byte <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            // Address is fixed at entry so it is stable through REQ..LOAD.
            if (w_take) begin
                r_vec_addr <= vec_addr_of(i_exc_code);
            end
            if ((r_state == ST_WAIT) && i_vec_rd_valid) begin
                r_vec_byte <= i_vec_rd_data;
            end
        end
    end

    assign o_exc_take   = w_take;
    assign o_load       = (r_state == ST_LOAD);
    assign o_vec_byte   = r_vec_byte;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_vec_rd_req = (r_state == ST_REQ);
    assign o_vec_addr   = r_vec_addr;

endmodule

// File: rtl/pc_unit.sv
// Program counter with EPC/cause capture; exceptions redirect the PC to
// a handler address read from the vector-byte table.
module pc_unit
    import pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_source,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        branch_taken,
    input  logic        exc_valid,
    input  logic [1:0]  exc_code,
    output logic        vec_rd_req,
    output logic [31:0] vec_addr,
    input  logic [7:0]  vec_rd_data,
    input  logic        vec_rd_valid,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic [1:0]  cause_out,
    output logic        exc_busy
);

    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [1:0]  r_cause;
    logic        w_exc_take;
    logic        w_load;
    logic [7:0]  w_vec_byte;
    logic        w_busy;
    logic        w_pc_we;

    pc_exc_fsm u_fsm (
        .clk            (clk),
        .reset          (reset),
        .i_exc_valid    (exc_valid),
        .i_exc_code     (exc_code),
        .i_vec_rd_data  (vec_rd_data),
        .i_vec_rd_valid (vec_rd_valid),
        .o_exc_take     (w_exc_take),
        .o_load         (w_load),
        .o_vec_byte     (w_vec_byte),
        .o_busy         (w_busy),
        .o_vec_rd_req   (vec_rd_req),
        .o_vec_addr     (vec_addr)
    );

    // An exception in the same cycle suppresses any PC write.
    assign w_pc_we = !w_busy && !exc_valid &&
                     (pc_write || (pc_write_cond && branch_taken));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= 32'd0;
            r_epc   <= 32'd0;
            r_cause <= 2'd0;
        end else begin
            if (w_load) begin
                r_pc <= {24'b0, w_vec_byte};
            end else if (w_pc_we) begin
                r_pc <= pc_source;
            end
            if (w_exc_take) begin
                r_epc   <= r_pc - 32'd4;
                r_cause <= exc_code;
            end
        end
    end

    assign pc_out    = r_pc;
    assign epc_out   = r_epc;
    assign cause_out = r_cause;
    assign exc_busy  = w_busy;

endmodule
